shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one 32-bit logarithmic left shifter between two requesters (port 0: ALU execute stage, port 1: multdiv sequencer) and returns registered results. It adds SRL and SRA by bit-reversing the operand and result around the left shifter. Each port has a valid/ready request channel and a valid/ready response channel. It sits beside the ALU in the execute stage and replaces per-unit shifter copies.

## Interface
- No parameters; data width is fixed at 32 and shift amount at 5 bits.
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a / req1_a  in  32  operand
- req0_amt / req1_amt  in  5  shift amount, 0–31
- req0_op / req1_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 pass (result = a)
- rsp0_valid / rsp1_valid  out  1  result held for port 0 / 1
- rsp0_ready / rsp1_ready  in  1  port consumes the result
- rsp_data  out  32  result; meaningful only while rsp0_valid or rsp1_valid is high

## Operation
- Two states:
  - EMPTY: no result held.
  - FULL: one result held, with owner bit `own`.
- can_accept = EMPTY, or (FULL and the owner's rspN_ready = 1).
- Grant selection:
  - Only one port valid: that port.
  - Both valid: port 0 wins (fixed priority), or the arbitration pointer decides when round-robin is compiled in.
- reqN_ready = can_accept and grant = N. It is combinational from the req*_valid and rsp*_ready inputs.
  - Requesters must not make valid depend on ready.
- On an accepted request:
  - Compute the result.
  - Register it into rsp_data.
  - Set own = N and state = FULL.
- Result computation:
  - SLL: shifter(a, amt).
  - SRL: rev(shifter(rev(a), amt)).
  - SRA: the SRL result OR'd with a sign-fill mask. The mask is ~rev(shifter(32'hFFFFFFFF, amt)) when a[31] = 1, and 0 otherwise.
- Response handshake completes when rspN_valid and rspN_ready are both high and own = N.
  - Completion with no new accept: go to EMPTY.
  - Completion with a same-cycle accept: stay FULL with the new data and owner.
- Only the owner's rspN_valid is ever high. The other port's rsp_ready is ignored.
- A stalled owner blocks both ports (head-of-line). There is no second buffer.

## Timing
- Reset values:
  - state = EMPTY, rsp0_valid = rsp1_valid = 0, rsp_data = 0, arbitration pointer = 0.
  - req*_ready follow combinationally, so they are 1 while EMPTY and a request is valid.
- Latency: a request accepted at edge N gives rspN_valid = 1 with data from N+1.
- Throughput: one result per cycle while the owner keeps rsp_ready = 1.
- Stall: while FULL and the owner's rsp_ready = 0:
  - rsp_data and own stay stable.
  - Both req_ready are 0.
- Boundary behaviour:
  - amt = 0 returns a for every op.
  - amt = 31 keeps a single bit (SLL/SRL) or the sign replicated (SRA).
  - Op 11 ignores amt.
- Reset asserted mid-operation discards any held result immediately, without waiting for a clock edge.
- Requests are never dropped or duplicated. An accepted request produces exactly one response.

## Configuration
- SHIFT_ARB_RR_EN defined:
  - Round-robin between the two ports. A 1-bit pointer names the preferred port and resets to 0.
  - After any grant, the pointer moves to the other port.
  - A port that was not granted becomes preferred, so neither port waits more than one grant.
- SHIFT_ARB_RR_EN undefined:
  - Fixed priority, port 0 always wins.
  - The pointer flop is absent.

## Structure
- Shared package shift_pkg holds:
  - op encodings SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_PASS = 2'b11
  - the FSM state constants
  - the 32-bit reverse function
- One sub-module: the existing combinational SLL barrel shifter (ports out, shiftamt, a).
  - Instantiated twice: once for the operand path, once for the SRA mask path with constant all-ones input.
- Arbitration, FSM, and response register live in shift_arbiter itself.

## Test plan
- Reset, then port 0 SLL a = 32'h0000_0001, amt = 31, rsp0_ready = 1 → rsp0_valid one cycle after accept, rsp_data = 32'h8000_0000, rsp1_valid stays 0.
- Port 1 SRA a = 32'h8000_0000, amt = 4 → 32'hF800_0000. Then SRL same operands → 32'h0800_0000. Then amt = 0 with each op → 32'h8000_0000.
- Both ports valid every cycle, both rsp_ready = 1:
  - Fixed priority: port 0 granted every cycle, req1_ready = 0.
  - SHIFT_ARB_RR_EN: grants alternate 0,1,0,1 with one result per cycle.
- Port 0 result held with rsp0_ready = 0 for 5 cycles while port 1 is valid → rsp_data stable, req1_ready = 0 throughout. Port 1 is granted in the cycle rsp0_ready rises.
- Op 11, a = 32'hDEAD_BEEF, amt = 7 → 32'hDEAD_BEEF.
- reset_n pulsed low while FULL → rsp*_valid = 0 and rsp_data = 0 immediately. The next request after reset_n rises completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter: op codes, holding-register states, bit reverse.
package shift_pkg;

   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_SRA  = 2'b10,
      SH_PASS = 2'b11
   } sh_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } arb_state_e;

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = x[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response channels of the two shifter clients; master = clients, slave = arbiter.
interface shift_arbiter_if;
   import shift_pkg::*;

   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [4:0]  req0_amt;
   sh_op_e      req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [4:0]  req1_amt;
   sh_op_e      req1_op;
   logic        rsp0_valid;
   logic        rsp0_ready;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp_data;

   modport master (
      output req0_valid, req0_a, req0_amt, req0_op,
      output req1_valid, req1_a, req1_amt, req1_op,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
   );

   modport slave (
      input  req0_valid, req0_a, req0_amt, req0_op,
      input  req1_valid, req1_a, req1_amt, req1_op,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
   );

endinterface

// File: rtl/shift_arbiter_sll.sv
// Combinational 32-bit logarithmic left shifter, five stages of 1/2/4/8/16.
module shift_arbiter_sll (
   output logic [31:0] out,
   input  logic [4:0]  shiftamt,
   input  logic [31:0] a
);

   logic [31:0] s0, s1, s2, s3;

   assign s0  = shiftamt[0] ? (a  << 1)  : a;
   assign s1  = shiftamt[1] ? (s0 << 2)  : s0;
   assign s2  = shiftamt[2] ? (s1 << 4)  : s1;
   assign s3  = shiftamt[3] ? (s2 << 8)  : s2;
   assign out = shiftamt[4] ? (s3 << 16) : s3;

endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter for one shared shifter; result registered (1 cycle), single holding slot blocks both ports while owner stalls.
// SHIFT_ARB_RR_EN selects round-robin arbitration instead of fixed port-0 priority.
module shift_arbiter
   import shift_pkg::*;
(
   input  logic           clock,
   input  logic           reset_n,
   shift_arbiter_if.slave bus
);

   arb_state_e  state_q, state_d;
   logic        own_q, own_d;
   logic [31:0] data_q, data_d;

   logic        pri0, gnt0, gnt1;
   logic        owner_take, can_accept, accept;
   logic [31:0] sel_a, sh_in, sh_out, mask_out, srl_res, result;
   logic [4:0]  sel_amt;
   sh_op_e      sel_op;

`ifdef SHIFT_ARB_RR_EN
   logic ptr_q;

   assign pri0 = ~ptr_q;

   // After a grant the port that just won becomes the non-preferred one.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= 1'b0;
      end else if (accept) begin
         ptr_q <= gnt0;
      end
   end
`else
   assign pri0 = 1'b1;
`endif

   assign gnt0 = bus.req0_valid & (~bus.req1_valid | pri0);
   assign gnt1 = bus.req1_valid & ~gnt0;

   assign owner_take = own_q ? bus.rsp1_ready : bus.rsp0_ready;
   assign can_accept = (state_q == ST_EMPTY) | owner_take;
   assign accept     = can_accept & (gnt0 | gnt1);

   assign bus.req0_ready = can_accept & gnt0;
   assign bus.req1_ready = can_accept & gnt1;

   assign sel_a   = gnt1 ? bus.req1_a   : bus.req0_a;
   assign sel_amt = gnt1 ? bus.req1_amt : bus.req0_amt;
   assign sel_op  = gnt1 ? bus.req1_op  : bus.req0_op;

   // Right shifts reuse the left shifter on the bit-reversed operand.
   assign sh_in = (sel_op == SH_SRL || sel_op == SH_SRA) ? rev32(sel_a) : sel_a;

   shift_arbiter_sll u_sll_data (
      .out      (sh_out),
      .shiftamt (sel_amt),
      .a        (sh_in)
   );

   shift_arbiter_sll u_sll_mask (
      .out      (mask_out),
      .shiftamt (sel_amt),
      .a        (32'hFFFF_FFFF)
   );

   assign srl_res = rev32(sh_out);

   always_comb begin
      result = sel_a;
      case (sel_op)
         SH_SLL:  result = sh_out;
         SH_SRL:  result = srl_res;
         SH_SRA:  result = srl_res | (sel_a[31] ? ~rev32(mask_out) : 32'h0);
         default: result = sel_a;
      endcase
   end

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      data_d  = data_q;
      if (accept) begin
         state_d = ST_FULL;
         own_d   = gnt1;
         data_d  = result;
      end else if (state_q == ST_FULL && owner_take) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         own_q   <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         data_q  <= data_d;
      end
   end

   assign bus.rsp0_valid = (state_q == ST_FULL) & ~own_q;
   assign bus.rsp1_valid = (state_q == ST_FULL) &  own_q;
   assign bus.rsp_data   = data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed cases, contention, stall, async reset, random ops vs arithmetic model.
module tb_shift_arbiter;
   import shift_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   fails = 0;

   shift_arbiter_if bus();

   shift_arbiter dut (
      .clock   (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] amt,
                                             input logic [1:0] op);
      logic signed [31:0] sa;
      sa = a;
      case (op)
         2'b00:   return a << amt;
         2'b01:   return a >> amt;
         2'b10:   return sa >>> amt;
         default: return a;
      endcase
   endfunction

   task automatic idle_inputs();
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_amt = '0; bus.req0_op = SH_SLL;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_amt = '0; bus.req1_op = SH_SLL;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
   endtask

   task automatic set_req(input int port, input logic [31:0] a, input logic [4:0] amt,
                          input logic [1:0] op);
      if (port == 0) begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_amt = amt; bus.req0_op = sh_op_e'(op);
      end else begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_amt = amt; bus.req1_op = sh_op_e'(op);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      #2;
      reset_n = 1'b1;
   endtask

   // Issues one request with both response readies high and returns what was observed.
   task automatic run_one(input int port, input logic [31:0] a, input logic [4:0] amt,
                          input logic [1:0] op, output logic rdy, output logic v0,
                          output logic v1, output logic [31:0] d);
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      set_req(port, a, amt, op);
      @(negedge clk);
      rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(negedge clk);
      v0 = bus.rsp0_valid; v1 = bus.rsp1_valid; d = bus.rsp_data;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 reset_n = 1'b0;
      bus.req0_valid = 1'b1;
      #1;
      checks++; if (bus.rsp0_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp0_valid got=%b exp=0", bus.rsp0_valid); end
      checks++; if (bus.rsp1_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp1_valid got=%b exp=0", bus.rsp1_valid); end
      checks++; if (bus.rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
      checks++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL reset_req0_ready got=%b exp=1", bus.req0_ready); end
      checks++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL reset_req1_ready got=%b exp=0", bus.req1_ready); end
      bus.req0_valid = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
   endtask

   task automatic test_sll();
      logic rdy, v0, v1;
      logic [31:0] d;
      run_one(0, 32'h0000_0001, 5'd31, 2'b00, rdy, v0, v1, d);
      checks++; if (rdy !== 1'b1) begin fails++; $display("FAIL sll_req0_ready got=%b exp=1", rdy); end
      checks++; if (v0 !== 1'b1) begin fails++; $display("FAIL sll_rsp0_valid got=%b exp=1", v0); end
      checks++; if (v1 !== 1'b0) begin fails++; $display("FAIL sll_rsp1_valid got=%b exp=0", v1); end
      checks++; if (d !== 32'h8000_0000) begin fails++; $display("FAIL sll_data got=%h exp=80000000", d); end
   endtask

   task automatic test_right_shifts();
      logic [4:0]  amts [5] = '{5'd4, 5'd4, 5'd0, 5'd0, 5'd0};
      logic [1:0]  ops  [5] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b10};
      logic [31:0] exps [5] = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      logic rdy, v0, v1;
      logic [31:0] d;
      for (int i = 0; i < 5; i++) begin
         run_one(1, 32'h8000_0000, amts[i], ops[i], rdy, v0, v1, d);
         checks++; if (v1 !== 1'b1 || v0 !== 1'b0) begin fails++; $display("FAIL shr_valids[%0d] got v0=%b v1=%b exp v0=0 v1=1", i, v0, v1); end
         checks++; if (d !== exps[i]) begin fails++; $display("FAIL shr_data[%0d] got=%h exp=%h", i, d, exps[i]); end
      end
   endtask

   task automatic test_pass();
      logic rdy, v0, v1;
      logic [31:0] d;
      run_one(0, 32'hDEAD_BEEF, 5'd7, 2'b11, rdy, v0, v1, d);
      checks++; if (d !== 32'hDEAD_BEEF) begin fails++; $display("FAIL pass_data got=%h exp=deadbeef", d); end
   endtask

   task automatic test_contend();
      logic        pend;
      logic        pend_port, exp_g, last_g;
      logic [31:0] pend_data;
      logic [31:0] a0, a1;
      logic [4:0]  m0, m1;
      logic [1:0]  o0, o1;
      pend = 1'b0; pend_port = 1'b0; pend_data = '0; last_g = 1'b1;
      pulse_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         a0 = $urandom; m0 = 5'($urandom_range(0, 31)); o0 = 2'($urandom_range(0, 3));
         a1 = $urandom; m1 = 5'($urandom_range(0, 31)); o1 = 2'($urandom_range(0, 3));
         set_req(0, a0, m0, o0);
         set_req(1, a1, m1, o1);
         @(negedge clk);
         if (pend) begin
            checks++; if (bus.rsp0_valid !== ~pend_port || bus.rsp1_valid !== pend_port) begin fails++; $display("FAIL contend_owner[%0d] got v0=%b v1=%b exp port %0d", i, bus.rsp0_valid, bus.rsp1_valid, pend_port); end
            checks++; if (bus.rsp_data !== pend_data) begin fails++; $display("FAIL contend_data[%0d] got=%h exp=%h", i, bus.rsp_data, pend_data); end
         end
`ifdef SHIFT_ARB_RR_EN
         exp_g = ~last_g;
`else
         exp_g = 1'b0;
`endif
         checks++; if (bus.req0_ready !== ~exp_g || bus.req1_ready !== exp_g) begin fails++; $display("FAIL contend_grant[%0d] got r0=%b r1=%b exp port %0d", i, bus.req0_ready, bus.req1_ready, exp_g); end
         pend = 1'b1;
         pend_port = exp_g;
         pend_data = exp_g ? ref_shift(a1, m1, o1) : ref_shift(a0, m0, o0);
         last_g = exp_g;
         @(posedge clk); #1;
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.rsp_data !== pend_data) begin fails++; $display("FAIL contend_last_data got=%h exp=%h", bus.rsp_data, pend_data); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin fails++; $display("FAIL contend_drain got v0=%b v1=%b exp both 0", bus.rsp0_valid, bus.rsp1_valid); end
   endtask

   task automatic test_stall();
      logic [31:0] a0, a1, e0, e1;
      a0 = $urandom; a1 = $urandom;
      e0 = ref_shift(a0, 5'd3, 2'b00);
      e1 = ref_shift(a1, 5'd9, 2'b10);
      pulse_reset();
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
      set_req(0, a0, 5'd3, 2'b00);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      set_req(1, a1, 5'd9, 2'b10);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin fails++; $display("FAIL stall_valids[%0d] got v0=%b v1=%b exp v0=1 v1=0", k, bus.rsp0_valid, bus.rsp1_valid); end
         checks++; if (bus.rsp_data !== e0) begin fails++; $display("FAIL stall_data[%0d] got=%h exp=%h", k, bus.rsp_data, e0); end
         checks++; if (bus.req1_ready !== 1'b0) begin fails++; $display("FAIL stall_req1_ready[%0d] got=%b exp=0", k, bus.req1_ready); end
         @(posedge clk); #1;
      end
      bus.rsp0_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.req1_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready got=%b exp=1", bus.req1_ready); end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0) begin fails++; $display("FAIL stall_next_valids got v0=%b v1=%b exp v0=0 v1=1", bus.rsp0_valid, bus.rsp1_valid); end
      checks++; if (bus.rsp_data !== e1) begin fails++; $display("FAIL stall_next_data got=%h exp=%h", bus.rsp_data, e1); end
   endtask

   task automatic test_reset_midop();
      logic rdy, v0, v1;
      logic [31:0] d;
      @(posedge clk); #1;
      bus.rsp0_ready = 1'b0;
      set_req(0, 32'h1234_5678, 5'd3, 2'b00);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.rsp0_valid !== 1'b1) begin fails++; $display("FAIL midrst_full got=%b exp=1", bus.rsp0_valid); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin fails++; $display("FAIL midrst_valids got v0=%b v1=%b exp both 0", bus.rsp0_valid, bus.rsp1_valid); end
      checks++; if (bus.rsp_data !== 32'h0) begin fails++; $display("FAIL midrst_data got=%h exp=0", bus.rsp_data); end
      #1 reset_n = 1'b1;
      bus.rsp0_ready = 1'b1;
      run_one(1, 32'hF000_000F, 5'd4, 2'b10, rdy, v0, v1, d);
      checks++; if (v1 !== 1'b1 || d !== 32'hFF00_0000) begin fails++; $display("FAIL midrst_after got v1=%b data=%h exp v1=1 data=ff000000", v1, d); end
   endtask

   task automatic test_random();
      logic rdy, v0, v1;
      logic [31:0] d, a, e;
      logic [4:0]  m;
      logic [1:0]  o;
      int          port;
      for (int i = 0; i < 40; i++) begin
         port = int'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       m = 5'd0;
            1:       m = 5'd31;
            default: m = 5'($urandom_range(0, 31));
         endcase
         o = 2'($urandom_range(0, 3));
         e = ref_shift(a, m, o);
         run_one(port, a, m, o, rdy, v0, v1, d);
         checks++; if (rdy !== 1'b1 || v0 !== (port == 0) || v1 !== (port == 1)) begin fails++; $display("FAIL rand_hs[%0d] got rdy=%b v0=%b v1=%b exp port %0d", i, rdy, v0, v1, port); end
         checks++; if (d !== e) begin fails++; $display("FAIL rand_data[%0d] a=%h amt=%0d op=%0d got=%h exp=%h", i, a, m, o, d, e); end
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_sll();
      test_right_shifts();
      test_pass();
      test_contend();
      test_stall();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
